i2c_slave_mem: RTL and testbench

- I2C target (responder) paired with the team's I2C master receiver.
- Contains a small byte-addressed register memory.
- Protocol supported:
  - Write: START, {DEV_ADDR,0}, word address, then N data bytes.
  - Random read: START, {DEV_ADDR,0}, word address, repeated START, {DEV_ADDR,1}, then N data bytes.
- SCL and SDA are oversampled on i_clk. The block never drives SCL (no clock stretching).

---
 rtl/i2c_pkg.sv | 32 +++
 rtl/i2c_slave_mem_if.sv | 17 +
 rtl/i2c_bus_sync.sv | 52 +++++
 rtl/i2c_slave_mem.sv | 202 ++++++++++++++++++++
 tb/tb_i2c_slave_mem.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module  : i2c_pkg
// Brief   : Shared I2C state encoding and protocol constants.
// Revision: 1.0
// ============================================================================
package i2c_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_DEV_ADDR  = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_WORD_ADDR = 4'd3,
        S_WA_ACK    = 4'd4,
        S_WR_DATA   = 4'd5,
        S_WR_ACK    = 4'd6,
        S_RD_DATA   = 4'd7,
        S_RD_ACK    = 4'd8
    } state_t;

    localparam logic c_I2C_WRITE = 1'b0;
    localparam logic c_I2C_READ  = 1'b1;
    localparam logic c_ACK       = 1'b0;
    localparam logic c_NACK      = 1'b1;

    // Open-drain: a 0 bit means pull the line low, a 1 bit means release it.
    function automatic logic sda_pull(input logic b);
        return (b == 1'b0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_slave_mem_if.sv
`default_nettype none
// ============================================================================
// Module  : i2c_slave_mem_if
// Brief   : SCL input and write-monitor outputs of the I2C memory target.
// Revision: 1.0
// ============================================================================
interface i2c_slave_mem_if;
    logic       scl;
    logic       busy;
    logic       wr_pulse;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;

    modport slave  (input  scl, output busy, output wr_pulse, output wr_addr, output wr_data);
    modport master (output scl, input  busy, input  wr_pulse, input  wr_addr, input  wr_data);
endinterface
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ============================================================================
// Module  : i2c_bus_sync
// Brief   : SCL/SDA synchronisers with edge, START and STOP detection.
// Revision: 1.0
// ============================================================================
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic i_clk,
    input  wire logic i_rst,
    input  wire logic i_scl,
    input  wire logic i_sda,
    output logic      o_sda,
    output logic      o_scl_rise,
    output logic      o_scl_fall,
    output logic      o_start,
    output logic      o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   w_scl;
    logic                   w_sda;

    // Stages preset to 1 so an idle bus produces no spurious edges after reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= (r_scl_sync << 1) | SYNC_STAGES'(i_scl);
            r_sda_sync <= (r_sda_sync << 1) | SYNC_STAGES'(i_sda);
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_d;
    assign o_scl_fall = ~w_scl & r_scl_d;
    assign o_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign o_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

endmodule
`default_nettype wire

// File: rtl/i2c_slave_mem.sv
`default_nettype none
// ============================================================================
// Module  : i2c_slave_mem
// Brief   : I2C target with a byte-addressed register memory (write/random read).
// Revision: 1.0
// ============================================================================
module i2c_slave_mem
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         DEPTH       = 16,
    parameter int         SYNC_STAGES = 2
) (
    input  wire logic      i_clk,
    input  wire logic      i_rst,
    i2c_slave_mem_if.slave bus,
    inout  wire logic      sda
);

    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t          r_state, w_state;
    logic [3:0]      r_cnt, w_cnt;
    logic [7:0]      r_shift, w_shift;
    logic [c_PW-1:0] r_ptr, w_ptr;
    logic            r_oe, w_oe;
    logic            r_busy, w_busy;
    logic            r_rw, w_rw;
    logic            r_wr_pulse, w_wr_pulse;
    logic [7:0]      r_wr_addr, w_wr_addr;
    logic [7:0]      r_wr_data, w_wr_data;
    logic            w_mem_we;
    logic [7:0]      r_mem [DEPTH];

    logic       w_sda_s, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_byte_in;
    logic [7:0] w_rd_byte;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_scl      (bus.scl),
        .i_sda      (sda),
        .o_sda      (w_sda_s),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    assign w_byte_in = {r_shift[6:0], w_sda_s};
    assign w_rd_byte = r_mem[r_ptr];

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_shift    = r_shift;
        w_ptr      = r_ptr;
        w_oe       = r_oe;
        w_busy     = r_busy;
        w_rw       = r_rw;
        w_wr_pulse = 1'b0;
        w_wr_addr  = r_wr_addr;
        w_wr_data  = r_wr_data;
        w_mem_we   = 1'b0;

        if (w_stop) begin
            w_state = S_IDLE;
            w_oe    = 1'b0;
            w_busy  = 1'b0;
            w_cnt   = 4'd0;
        end else if (w_start) begin
            // Pointer is deliberately kept so a repeated START can read it back.
            w_state = S_DEV_ADDR;
            w_oe    = 1'b0;
            w_cnt   = 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_busy = 1'b0;
                end
                S_DEV_ADDR, S_WORD_ADDR, S_WR_DATA: begin
                    if (w_scl_rise && r_cnt < 4'd8) begin
                        w_shift = w_byte_in;
                        w_cnt   = r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            if (r_state == S_DEV_ADDR && w_byte_in[7:1] != DEV_ADDR) begin
                                w_state = S_IDLE;
                                w_oe    = 1'b0;
                                w_busy  = 1'b0;
                            end else if (r_state == S_WORD_ADDR) begin
                                w_ptr = w_byte_in[c_PW-1:0];
                            end else if (r_state == S_WR_DATA) begin
                                w_mem_we   = 1'b1;
                                w_wr_pulse = 1'b1;
                                w_wr_addr  = 8'(r_ptr);
                                w_wr_data  = w_byte_in;
                                w_ptr      = r_ptr + 1'b1;
                            end
                        end
                    end else if (w_scl_fall && r_cnt == 4'd8) begin
                        w_oe = sda_pull(c_ACK);
                        case (r_state)
                            S_DEV_ADDR: begin
                                w_busy  = 1'b1;
                                w_rw    = r_shift[0];
                                w_state = S_ADDR_ACK;
                            end
                            S_WORD_ADDR: w_state = S_WA_ACK;
                            default:     w_state = S_WR_ACK;
                        endcase
                    end
                end
                S_ADDR_ACK, S_RD_ACK: begin
                    if (r_state == S_RD_ACK && w_scl_rise) begin
                        if (w_sda_s == c_NACK) begin
                            w_state = S_IDLE;
                            w_busy  = 1'b0;
                        end else begin
                            w_ptr = r_ptr + 1'b1;
                        end
                    end else if (w_scl_fall) begin
                        w_oe  = 1'b0;
                        w_cnt = 4'd0;
                        if (r_state == S_RD_ACK || r_rw == c_I2C_READ) begin
                            w_shift = w_rd_byte;
                            w_oe    = sda_pull(w_rd_byte[7]);
                            w_cnt   = 4'd1;
                            w_state = S_RD_DATA;
                        end else begin
                            w_state = S_WORD_ADDR;
                        end
                    end
                end
                S_WA_ACK, S_WR_ACK: begin
                    if (w_scl_fall) begin
                        w_oe    = 1'b0;
                        w_cnt   = 4'd0;
                        w_state = S_WR_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (w_scl_fall) begin
                        if (r_cnt == 4'd8) begin
                            w_oe    = 1'b0;
                            w_state = S_RD_ACK;
                        end else begin
                            w_shift = r_shift << 1;
                            w_oe    = sda_pull(r_shift[6]);
                            w_cnt   = r_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    w_state = S_IDLE;
                    w_oe    = 1'b0;
                    w_busy  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_shift    <= 8'd0;
            r_ptr      <= '0;
            r_oe       <= 1'b0;
            r_busy     <= 1'b0;
            r_rw       <= c_I2C_WRITE;
            r_wr_pulse <= 1'b0;
            r_wr_addr  <= 8'd0;
            r_wr_data  <= 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'd0;
            end
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_shift    <= w_shift;
            r_ptr      <= w_ptr;
            r_oe       <= w_oe;
            r_busy     <= w_busy;
            r_rw       <= w_rw;
            r_wr_pulse <= w_wr_pulse;
            r_wr_addr  <= w_wr_addr;
            r_wr_data  <= w_wr_data;
            if (w_mem_we) begin
                r_mem[r_ptr] <= w_byte_in;
            end
        end
    end

    assign sda          = r_oe ? 1'b0 : 1'bz;
    assign bus.busy     = r_busy;
    assign bus.wr_pulse = r_wr_pulse;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_mem.sv
`default_nettype none
// ============================================================================
// Module  : tb_i2c_slave_mem
// Brief   : Directed bench for i2c_slave_mem acting as the I2C master.
// Revision: 1.0
// ============================================================================
module tb_i2c_slave_mem;

    localparam int c_H = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       m_sda_low;
    wire        sda;
    int         n_vec = 0;
    int         n_err = 0;
    int         n_wr  = 0;
    logic [7:0] cap_addr [16];
    logic [7:0] cap_data [16];
    logic       ack;
    logic [7:0] rd;

    i2c_slave_mem_if bus ();

    i2c_slave_mem #(.DEV_ADDR(7'h50), .DEPTH(16), .SYNC_STAGES(2)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus),
        .sda   (sda)
    );

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup pu_sda (sda);

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wr_pulse === 1'b1 && n_wr < 16) begin
            cap_addr[n_wr] = bus.wr_addr;
            cap_data[n_wr] = bus.wr_data;
            n_wr++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        wait_clk(2);
        m_sda_low = ~b;
        wait_clk(c_H);
        bus.scl = 1'b1;
        wait_clk(c_H);
        bus.scl = 1'b0;
    endtask

    task automatic i2c_start();
        wait_clk(2);
        m_sda_low = 1'b0;
        wait_clk(c_H);
        bus.scl = 1'b1;
        wait_clk(c_H);
        m_sda_low = 1'b1;
        wait_clk(c_H);
        bus.scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(2);
        m_sda_low = 1'b1;
        wait_clk(c_H);
        bus.scl = 1'b1;
        wait_clk(c_H);
        m_sda_low = 1'b0;
        wait_clk(c_H);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        wait_clk(2);
        m_sda_low = 1'b0;
        wait_clk(c_H);
        bus.scl = 1'b1;
        wait_clk(c_H / 2);
        a = sda;
        wait_clk(c_H - c_H / 2);
        bus.scl = 1'b0;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack_bit);
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            wait_clk(2);
            m_sda_low = 1'b0;
            wait_clk(c_H);
            bus.scl = 1'b1;
            wait_clk(c_H / 2);
            d = {d[6:0], sda};
            wait_clk(c_H - c_H / 2);
            bus.scl = 1'b0;
        end
        send_bit(ack_bit);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        m_sda_low = 1'b0;
        bus.scl   = 1'b1;
        wait_clk(5);
        check("rst_sda",      {31'd0, sda},          32'd1);
        check("rst_busy",     {31'd0, bus.busy},     32'd0);
        check("rst_wr_pulse", {31'd0, bus.wr_pulse}, 32'd0);
        check("rst_wr_addr",  {24'd0, bus.wr_addr},  32'h00);
        check("rst_wr_data",  {24'd0, bus.wr_data},  32'h00);
        rst = 1'b0;
        wait_clk(5);

        // Write A5, 3C starting at word 0x04.
        i2c_start();
        write_byte(8'hA0, ack); check("wr_dev_ack", {31'd0, ack}, 32'd0);
        check("wr_busy_hi", {31'd0, bus.busy}, 32'd1);
        write_byte(8'h04, ack); check("wr_wa_ack",  {31'd0, ack}, 32'd0);
        write_byte(8'hA5, ack); check("wr_d0_ack",  {31'd0, ack}, 32'd0);
        write_byte(8'h3C, ack); check("wr_d1_ack",  {31'd0, ack}, 32'd0);
        i2c_stop();
        check("wr_busy_lo", {31'd0, bus.busy}, 32'd0);
        check("wr_count",   n_wr, 32'd2);
        check("wr0_addr",   {24'd0, cap_addr[0]}, 32'h04);
        check("wr0_data",   {24'd0, cap_data[0]}, 32'hA5);
        check("wr1_addr",   {24'd0, cap_addr[1]}, 32'h05);
        check("wr1_data",   {24'd0, cap_data[1]}, 32'h3C);
        check("wr_hold_addr", {24'd0, bus.wr_addr}, 32'h05);

        // Random read of two bytes from word 0x04.
        i2c_start();
        write_byte(8'hA0, ack); check("rr_dev_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h04, ack); check("rr_wa_ack",  {31'd0, ack}, 32'd0);
        i2c_start();
        write_byte(8'hA1, ack); check("rr_rd_ack",  {31'd0, ack}, 32'd0);
        read_byte(rd, 1'b0);    check("rr_byte0",   {24'd0, rd}, 32'hA5);
        read_byte(rd, 1'b1);    check("rr_byte1",   {24'd0, rd}, 32'h3C);
        wait_clk(4);
        check("rr_nack_idle", {31'd0, bus.busy}, 32'd0);
        check("rr_nack_sda",  {31'd0, sda},      32'd1);
        i2c_stop();

        // Wrong device address 0x51: no ACK, no activity.
        i2c_start();
        write_byte(8'hA2, ack); check("na_dev_nack", {31'd0, ack}, 32'd1);
        check("na_busy", {31'd0, bus.busy}, 32'd0);
        write_byte(8'h00, ack); check("na_byte_nack", {31'd0, ack}, 32'd1);
        i2c_stop();
        check("na_no_write", n_wr, 32'd2);

        // Pointer wrap from 0x0F.
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h0F, ack);
        write_byte(8'h11, ack);
        write_byte(8'h22, ack);
        write_byte(8'h33, ack); check("wrap_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        check("wrap_count", n_wr, 32'd5);
        check("wrap0_addr", {24'd0, cap_addr[2]}, 32'h0F);
        check("wrap1_addr", {24'd0, cap_addr[3]}, 32'h00);
        check("wrap1_data", {24'd0, cap_data[3]}, 32'h22);
        check("wrap2_addr", {24'd0, cap_addr[4]}, 32'h01);

        // STOP after four data bits aborts the byte.
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h08, ack);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        i2c_stop();
        check("abort_no_write", n_wr, 32'd5);
        check("abort_busy",     {31'd0, bus.busy}, 32'd0);
        check("abort_sda",      {31'd0, sda},      32'd1);

        // Read word 0x00 (0x22, MSB 0), then reset while the target pulls low.
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h00, ack);
        i2c_start();
        write_byte(8'hA1, ack);
        wait_clk(5);
        check("rd_drive_low", {31'd0, sda}, 32'd0);
        rst = 1'b1;
        wait_clk(1);
        check("rst_mid_sda",  {31'd0, sda},      32'd1);
        check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        wait_clk(3);
        rst = 1'b0;
        wait_clk(3);
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h04, ack);
        i2c_start();
        write_byte(8'hA1, ack);
        read_byte(rd, 1'b1); check("mem_cleared", {24'd0, rd}, 32'h00);
        i2c_stop();

        // Repeated START from WR_DATA keeps the pointer.
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h02, ack);
        write_byte(8'h77, ack);
        write_byte(8'h88, ack);
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h02, ack);
        write_byte(8'h99, ack);
        i2c_start();
        write_byte(8'hA1, ack); check("rs_dev_ack", {31'd0, ack}, 32'd0);
        read_byte(rd, 1'b0);    check("rs_byte0",   {24'd0, rd}, 32'h88);
        read_byte(rd, 1'b1);    check("rs_byte1",   {24'd0, rd}, 32'h00);
        i2c_stop();
        check("rs_count",   n_wr, 32'd8);
        check("rs_wr_addr", {24'd0, cap_addr[7]}, 32'h02);
        check("rs_wr_data", {24'd0, cap_data[7]}, 32'h99);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
